// File: rtl/bus_arbiter.sv
// bus_arbiter: 4-master round-robin arbiter with hold limit and slave-side bus mux
module bus_arbiter #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_as_,
  input  logic              m0_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic              m1_req_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_as_,
  input  logic              m1_rw,
  input  logic [DATA_W-1:0] m1_wr_data,
  input  logic              m2_req_,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic              m2_as_,
  input  logic              m2_rw,
  input  logic [DATA_W-1:0] m2_wr_data,
  input  logic              m3_req_,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m3_as_,
  input  logic              m3_rw,
  input  logic [DATA_W-1:0] m3_wr_data,
  output logic              m0_grnt_,
  output logic              m1_grnt_,
  output logic              m2_grnt_,
  output logic              m3_grnt_,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data,
  output logic              arb_preempt
);
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);
  logic [1:0] owner, o1, o2, o3, nxt;
  logic [CW-1:0] hold_cnt;
  logic [3:0] req;
  logic others, own_req, sel_as;
  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign o1 = owner + 2'd1;
  assign o2 = owner + 2'd2;
  assign o3 = owner + 2'd3;
  assign nxt = req[o1] ? o1 : req[o2] ? o2 : o3;
  assign own_req = req[owner];
  assign others = |(req & ~(4'b0001 << owner));
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= 2'd0;
      hold_cnt <= '0;
      arb_preempt <= 1'b0;
    end else begin
      arb_preempt <= 1'b0;
      if (others && !own_req) begin
        owner <= nxt;
        hold_cnt <= '0;
      end else if (others) begin
        if (hold_cnt == LAST) begin
          owner <= nxt;
          hold_cnt <= '0;
          arb_preempt <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end
  assign m0_grnt_ = owner != 2'd0;
  assign m1_grnt_ = owner != 2'd1;
  assign m2_grnt_ = owner != 2'd2;
  assign m3_grnt_ = owner != 2'd3;
  always_comb begin
    s_addr    = owner == 2'd0 ? m0_addr    : owner == 2'd1 ? m1_addr    : owner == 2'd2 ? m2_addr    : m3_addr;
    sel_as    = owner == 2'd0 ? m0_as_     : owner == 2'd1 ? m1_as_     : owner == 2'd2 ? m2_as_     : m3_as_;
    s_rw      = owner == 2'd0 ? m0_rw      : owner == 2'd1 ? m1_rw      : owner == 2'd2 ? m2_rw      : m3_rw;
    s_wr_data = owner == 2'd0 ? m0_wr_data : owner == 2'd1 ? m1_wr_data : owner == 2'd2 ? m2_wr_data : m3_wr_data;
    s_as_     = own_req ? sel_as : 1'b1;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven check of grants/preempt plus directed mux sequences
module tb_bus_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req_ = 4'hF;
  logic [3:0] as_ = 4'h0;
  logic [3:0] rw = 4'hF;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] wd [4];
  logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, s_as_, s_rw, arb_preempt;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wr_data;
  logic [3:0] grnt;
  assign grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(req_[0]), .m0_addr(addr[0]), .m0_as_(as_[0]), .m0_rw(rw[0]), .m0_wr_data(wd[0]),
    .m1_req_(req_[1]), .m1_addr(addr[1]), .m1_as_(as_[1]), .m1_rw(rw[1]), .m1_wr_data(wd[1]),
    .m2_req_(req_[2]), .m2_addr(addr[2]), .m2_as_(as_[2]), .m2_rw(rw[2]), .m2_wr_data(wd[2]),
    .m3_req_(req_[3]), .m3_addr(addr[3]), .m3_as_(as_[3]), .m3_rw(rw[3]), .m3_wr_data(wd[3]),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
    .arb_preempt(arb_preempt)
  );
  typedef struct {
    logic       r;
    logic [3:0] req;
    logic [3:0] g;
    logic       p;
  } vec_t;
  vec_t tv [$];
  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input logic p);
    tv.push_back('{r, q, g, p});
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      addr[i] = AW'(32'h100 * (i + 1));
      wd[i] = 32'h1111_1111 * (i + 1);
    end
    add(1, 4'b1111, 4'b1110, 0);
    add(0, 4'b1111, 4'b1110, 0);
    add(0, 4'b1011, 4'b1011, 0);
    add(0, 4'b1011, 4'b1011, 0);
    add(0, 4'b0101, 4'b0111, 0);
    add(0, 4'b1100, 4'b1110, 0);
    add(0, 4'b1101, 4'b1101, 0);
    add(0, 4'b1001, 4'b1101, 0);
    add(0, 4'b1001, 4'b1101, 0);
    add(0, 4'b1001, 4'b1101, 0);
    add(0, 4'b1001, 4'b1011, 1);
    add(0, 4'b1001, 4'b1011, 0);
    add(0, 4'b1001, 4'b1011, 0);
    add(0, 4'b1001, 4'b1011, 0);
    add(0, 4'b1101, 4'b1101, 0);
    add(0, 4'b0111, 4'b0111, 0);
    add(0, 4'b1010, 4'b1110, 0);
    add(0, 4'b1011, 4'b1011, 0);
    add(1, 4'b1011, 4'b1110, 0);
    add(0, 4'b1011, 4'b1011, 0);
    add(0, 4'b1010, 4'b1011, 0);
    add(0, 4'b1010, 4'b1011, 0);
    add(1, 4'b1010, 4'b1110, 0);
    add(0, 4'b1010, 4'b1110, 0);
    add(0, 4'b1010, 4'b1110, 0);
    add(0, 4'b1010, 4'b1110, 0);
    add(0, 4'b1010, 4'b1011, 1);
    foreach (tv[i]) begin
      @(negedge clk);
      reset = tv[i].r;
      req_ = tv[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("grnt[%0d]", i), 64'(grnt), 64'(tv[i].g));
      chk($sformatf("preempt[%0d]", i), 64'(arb_preempt), 64'(tv[i].p));
    end
    @(negedge clk);
    req_ = 4'b0111;
    @(posedge clk);
    #1;
    chk("grnt_m3", 64'(grnt), 64'(4'b0111));
    @(negedge clk);
    addr[3] = 30'h1C00_0004;
    as_[3] = 1'b0;
    rw[3] = 1'b0;
    wd[3] = 32'hDEAD_BEEF;
    #1;
    chk("mux_addr", 64'(s_addr), 64'(30'h1C00_0004));
    chk("mux_as", 64'(s_as_), 64'(1'b0));
    chk("mux_rw", 64'(s_rw), 64'(1'b0));
    chk("mux_wd", 64'(s_wr_data), 64'(32'hDEAD_BEEF));
    addr[0] = 30'h0000_0ABC;
    wd[0] = 32'h0BAD_F00D;
    as_[0] = 1'b1;
    rw[0] = 1'b1;
    #1;
    chk("mux_addr_hold", 64'(s_addr), 64'(30'h1C00_0004));
    chk("mux_wd_hold", 64'(s_wr_data), 64'(32'hDEAD_BEEF));
    chk("mux_rw_hold", 64'(s_rw), 64'(1'b0));
    req_ = 4'b1111;
    #1;
    chk("as_forced", 64'(s_as_), 64'(1'b1));
    @(posedge clk);
    #1;
    chk("idle_park", 64'(grnt), 64'(4'b0111));
    chk("idle_preempt", 64'(arb_preempt), 64'(1'b0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
